// File: rtl/shadd_div.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock.
// Optional divide-by-zero early exit and dz flag enabled by defining SHADD_DIV_DZ_EN.
module shadd_div #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strt,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem,
  output logic         done,
`ifdef SHADD_DIV_DZ_EN
  output logic         dz,
`endif
  output logic         busy
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  r_q;       // partial remainder magnitude
  logic [N-1:0]  q_q;       // dividend bits shifting out, quotient bits shifting in
  logic [N-1:0]  bm_q;
  logic          qs_q;
  logic          rs_q;
  logic [CW-1:0] cnt_q;

  logic          load_c;
  logic          fin_c;
  logic          last_c;
  logic          zero_c;
  logic          ge_c;
  logic [N:0]    tmp_c;
  logic [N-1:0]  am_c;
  logic [N-1:0]  bm_c;
  logic [N-1:0]  r_nxt_c;
  logic [N-1:0]  q_nxt_c;
  logic [N-1:0]  rem_mag_c;
  logic [N-1:0]  quo_fin_c;
  logic [N-1:0]  rem_fin_c;

  function automatic logic [N-1:0] neg(input logic [N-1:0] x);
    return ~x + N'(1);
  endfunction

  // Operand magnitudes; -2^(N-1) maps onto the unsigned value 2^(N-1)
  always_comb begin
    am_c = a[N-1] ? neg(a) : a;
    bm_c = b[N-1] ? neg(b) : b;
  end

  // One restoring step: shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    tmp_c   = {r_q, q_q[N-1]};
    ge_c    = (tmp_c >= {1'b0, bm_q});
    r_nxt_c = ge_c ? (tmp_c[N-1:0] - bm_q) : tmp_c[N-1:0];
    q_nxt_c = {q_q[N-2:0], ge_c};
    last_c  = (cnt_q == CW'(N - 1));
`ifdef SHADD_DIV_DZ_EN
    zero_c  = (bm_q == '0);
`else
    zero_c  = 1'b0;
`endif
  end

  // Sign correction; on the divide-by-zero exit q_q still holds |a|, so rem rebuilds a
  always_comb begin
    rem_mag_c = zero_c ? q_q : r_nxt_c;
    rem_fin_c = rs_q ? neg(rem_mag_c) : rem_mag_c;
    if (zero_c) begin
      quo_fin_c = '1;
    end else begin
      quo_fin_c = qs_q ? neg(q_nxt_c) : q_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    fin_c     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (strt) begin
          state_nxt = CALC;
          load_c    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (last_c || zero_c) begin
          state_nxt = DONE;
          fin_c     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      q_q   <= '0;
      bm_q  <= '0;
      qs_q  <= 1'b0;
      rs_q  <= 1'b0;
      cnt_q <= '0;
      quo   <= '0;
      rem   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
`ifdef SHADD_DIV_DZ_EN
      dz    <= 1'b0;
`endif
    end else begin
      done <= (state_nxt == DONE);
      busy <= (state_nxt == CALC);
      if (load_c) begin
        r_q   <= '0;
        q_q   <= am_c;
        bm_q  <= bm_c;
        qs_q  <= a[N-1] ^ b[N-1];
        rs_q  <= a[N-1];
        cnt_q <= '0;
      end else if (state == CALC) begin
        r_q   <= r_nxt_c;
        q_q   <= q_nxt_c;
        cnt_q <= cnt_q + CW'(1);
      end
      if (fin_c) begin
        quo <= quo_fin_c;
        rem <= rem_fin_c;
`ifdef SHADD_DIV_DZ_EN
        dz  <= zero_c;
`endif
      end
    end
  end

endmodule
